// File: rtl/irom_arbiter_pkg.sv
// Shared definitions for the instruction-ROM arbiter: FSM encoding,
// bus transfer-type constants and the ROM window check.
package irom_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // True when addr lies in [start, start+size); the upper bound is formed
    // one bit wider so a window reaching the top of the address space never wraps.
    function automatic logic in_window(input logic [16:0] addr,
                                       input logic [16:0] start,
                                       input int unsigned size);
        logic [17:0] limit;
        limit = {1'b0, start} + size[17:0];
        return (addr >= start) && ({1'b0, addr} < limit);
    endfunction

endpackage

// File: rtl/irom_arbiter_rr.sv
// Two-way round-robin tie-breaker: one-hot grant plus a pointer that
// remembers which requester won last. The pointer moves only on a real grant.
module rr_arb2 (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] grant
);

    logic last_m1;

    // Pick the single requester, or on a tie the one that did not win last.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_m1 ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner; reset favours m0 on the first tie.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            last_m1 <= 1'b1;
        end else if (take && (grant != 2'b00)) begin
            last_m1 <= grant[1];
        end
    end

endmodule

// File: rtl/irom_arbiter.sv
// Arbitrates two requesters onto a single instruction-ROM port using a
// fixed IDLE/ADDR/DATA walk; out-of-window and protected writes still walk
// the states but never reach the ROM.
module irom_arbiter
    import irom_arbiter_pkg::*;
#(
    parameter logic [16:0] ROM_START   = 17'h0,
    parameter int unsigned ROM_SIZE    = 256,
    parameter bit          M0_WRITE_EN = 1'b0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        m0_req,
    input  logic [16:0] m0_addr,
    input  logic [16:0] m0_wdata,
    input  logic        m0_write,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [16:0] m0_rdata,
    input  logic        m1_req,
    input  logic [16:0] m1_addr,
    input  logic [16:0] m1_wdata,
    input  logic        m1_write,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [16:0] m1_rdata,
    output logic [16:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [16:0] HWDATA,
    output logic        HWRITE,
    input  logic [16:0] HRDATA
);

    state_t      state, state_next;
    logic [1:0]  grant;
    logic        idle;
    logic [16:0] sel_addr, sel_wdata;
    logic        sel_write;
    logic        lat_owner, lat_write, lat_oob, lat_prot;
    logic [16:0] lat_addr, lat_wdata;
    logic        drive_rom;

    assign idle      = (state == ST_IDLE);
    assign drive_rom = (state == ST_ADDR) && !lat_oob && !lat_prot;

    rr_arb2 u_rr (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .req    ({m1_req, m0_req}),
        .take   (idle),
        .grant  (grant)
    );

    // Route the winning requester's transfer fields toward the latch.
    always_comb begin
        sel_addr  = grant[1] ? m1_addr  : m0_addr;
        sel_wdata = grant[1] ? m1_wdata : m0_wdata;
        sel_write = grant[1] ? m1_write : m0_write;
    end

    // State register for the three-phase transfer walk.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave IDLE only on a grant, then always ADDR -> DATA -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant != 2'b00) state_next = ST_ADDR;
            ST_ADDR: state_next = ST_DATA;
            ST_DATA: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture the winner's request at grant so later input changes are ignored.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            lat_owner <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
            lat_oob   <= 1'b0;
            lat_prot  <= 1'b0;
        end else if (idle && (grant != 2'b00)) begin
            lat_owner <= grant[1];
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            lat_write <= sel_write;
            lat_oob   <= !in_window(sel_addr, ROM_START, ROM_SIZE);
            lat_prot  <= !grant[1] && sel_write && !M0_WRITE_EN;
        end
    end

    // Present the transfer to the ROM only during a permitted ADDR phase.
    always_comb begin
        HADDR  = '0;
        HWDATA = '0;
        HWRITE = 1'b0;
        HTRANS = HTRANS_IDLE;
        if (drive_rom) begin
            HADDR  = lat_addr;
            HWDATA = lat_wdata;
            HWRITE = lat_write;
            HTRANS = HTRANS_NONSEQ;
        end
    end

    // Complete the transfer at the DATA->IDLE edge toward the owner only.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            m0_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m0_rdata <= '0;
            m1_ack   <= 1'b0;
            m1_err   <= 1'b0;
            m1_rdata <= '0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            if (state == ST_DATA) begin
                if (lat_owner) begin
                    m1_ack <= 1'b1;
                    m1_err <= lat_oob | lat_prot;
                    if (lat_oob) begin
                        m1_rdata <= '0;
                    end else if (!lat_write) begin
                        m1_rdata <= HRDATA;
                    end
                end else begin
                    m0_ack <= 1'b1;
                    m0_err <= lat_oob | lat_prot;
                    if (lat_oob) begin
                        m0_rdata <= '0;
                    end else if (!lat_write) begin
                        m0_rdata <= HRDATA;
                    end
                end
            end
        end
    end

endmodule
